lcd_mem_sched: RTL

- Scheduler that owns the display port (cond / crw / IN / dis_out) of the team's three-bank memory_module.
- Shares that port between two requesters:
  - an external write requester (keypad/host), using a req/ack handshake;
  - an internal display-refresh scanner, which reads cells 0..NUM_CELLS-1 in order and hands each byte to the LCD driver over a valid/ready handshake.
- Sits between memory_module and the LCD driver. A burst cap prevents writes from starving refresh.

---
 rtl/lcd_mem_sched_if.sv | 41 ++++
 rtl/lcd_mem_sched.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lcd_mem_sched_if.sv
// lcd_mem_sched_if
//   Bundles every signal between the display-port scheduler and its three
//   neighbours: the write requester, the LCD driver and the memory display port.
//
//   Write requester : wr_req, wr_addr, wr_data -> scheduler; wr_ack <- scheduler
//   LCD driver      : lcd_data, lcd_addr, lcd_valid, frame_done <- scheduler;
//                     lcd_ready -> scheduler
//   Refresh control : scan_en -> scheduler
//   Memory port     : cond, crw, mem_in <- scheduler; dis_out -> scheduler
//
//   Modport slave is the scheduler's view. Modport master is the view of
//   everything around it.
interface lcd_mem_sched_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              scan_en;
  logic [DATA_W-1:0] lcd_data;
  logic [ADDR_W-1:0] lcd_addr;
  logic              lcd_valid;
  logic              lcd_ready;
  logic              frame_done;
  logic [ADDR_W-1:0] cond;
  logic [1:0]        crw;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] dis_out;

  modport slave (
    input  wr_req, wr_addr, wr_data, scan_en, lcd_ready, dis_out,
    output wr_ack, lcd_data, lcd_addr, lcd_valid, frame_done, cond, crw, mem_in
  );

  modport master (
    output wr_req, wr_addr, wr_data, scan_en, lcd_ready, dis_out,
    input  wr_ack, lcd_data, lcd_addr, lcd_valid, frame_done, cond, crw, mem_in
  );
endinterface

// File: rtl/lcd_mem_sched.sv
// lcd_mem_sched
//   Owns the single display port of the memory module. It shares that port
//   between two users:
//   - external writes, using a req/ack handshake;
//   - a refresh scanner that reads cells 0..NUM_CELLS-1 in turn and hands each
//     byte to the LCD driver over a valid/ready handshake.
//   While a refresh read is waiting, at most WR_BURST_MAX writes in a row are
//   granted. This stops a steady stream of writes from starving the refresh.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - lcd_mem_sched_if.slave; carries the write handshake, the LCD
//            handshake, scan_en and the memory port (cond/crw/mem_in/dis_out)
//
//   Memory commands on crw: 2'b10 = write (commits on that edge),
//   2'b11 = read (dis_out is valid the following cycle), 2'b00 = idle.
module lcd_mem_sched #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int NUM_CELLS    = 32,
  parameter int WR_BURST_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  lcd_mem_sched_if.slave bus
);

  localparam int BW = $clog2(WR_BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [ADDR_W-1:0] scan_ptr_reg;
  logic [BW-1:0]     burst_cnt_reg;
  logic [DATA_W-1:0] lcd_data_reg;
  logic [ADDR_W-1:0] lcd_addr_reg;
  logic              lcd_valid_reg;
  logic              frame_done_reg;

  logic              read_ok;
  logic              burst_at_max;
  logic              latch_wr;
  logic              burst_inc;
  logic              burst_clr;
  logic              load_lcd;
  logic              lcd_accept;
  logic [ADDR_W-1:0] cond_next;
  logic [1:0]        crw_next;
  logic [DATA_W-1:0] mem_in_next;
  logic              wr_ack_next;

  assign burst_at_max = (burst_cnt_reg == BW'(WR_BURST_MAX));
  assign lcd_accept   = lcd_valid_reg && bus.lcd_ready;

  always_comb begin
    state_next  = state_reg;
    cond_next   = '0;
    crw_next    = 2'b00;
    mem_in_next = '0;
    wr_ack_next = 1'b0;
    latch_wr    = 1'b0;
    burst_inc   = 1'b0;
    burst_clr   = 1'b0;
    load_lcd    = 1'b0;
    // A new read may start only once the previous byte has left the output
    // register.
    read_ok     = bus.scan_en && !lcd_valid_reg;

    case (state_reg)
      IDLE: begin
        // Writes win. The exception is a pending refresh read after a full
        // burst of writes; then the read goes first.
        if (bus.wr_req && !(read_ok && burst_at_max)) begin
          latch_wr   = 1'b1;
          state_next = WRITE;
        end else if (read_ok) begin
          state_next = READ;
        end
      end
      WRITE: begin
        // If reset arrives during the write cycle, the command and the ack
        // are suppressed. No half-committed write is acknowledged, and the
        // requester simply asks again.
        if (!rst) begin
          cond_next   = wr_addr_reg;
          mem_in_next = wr_data_reg;
          crw_next    = 2'b10;
          wr_ack_next = 1'b1;
        end
        burst_inc  = 1'b1;
        state_next = IDLE;
      end
      READ: begin
        cond_next  = scan_ptr_reg;
        crw_next   = 2'b11;
        burst_clr  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        load_lcd   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      scan_ptr_reg   <= '0;
      burst_cnt_reg  <= '0;
      lcd_data_reg   <= '0;
      lcd_addr_reg   <= '0;
      lcd_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (latch_wr) begin
        wr_addr_reg <= bus.wr_addr;
        wr_data_reg <= bus.wr_data;
      end

      if (burst_clr)
        burst_cnt_reg <= '0;
      else if (burst_inc && !burst_at_max)
        burst_cnt_reg <= burst_cnt_reg + 1'b1;

      // load_lcd and lcd_accept never coincide: lcd_valid is low
      // throughout a read.
      if (load_lcd) begin
        lcd_data_reg  <= bus.dis_out;
        lcd_addr_reg  <= scan_ptr_reg;
        lcd_valid_reg <= 1'b1;
      end else if (lcd_accept) begin
        lcd_valid_reg <= 1'b0;
        scan_ptr_reg  <= (scan_ptr_reg == ADDR_W'(NUM_CELLS - 1)) ? '0
                                                                  : scan_ptr_reg + 1'b1;
      end

      frame_done_reg <= lcd_accept && (lcd_addr_reg == ADDR_W'(NUM_CELLS - 1));
    end
  end

  assign bus.cond       = cond_next;
  assign bus.crw        = crw_next;
  assign bus.mem_in     = mem_in_next;
  assign bus.wr_ack     = wr_ack_next;
  assign bus.lcd_data   = lcd_data_reg;
  assign bus.lcd_addr   = lcd_addr_reg;
  assign bus.lcd_valid  = lcd_valid_reg;
  assign bus.frame_done = frame_done_reg;

endmodule
